bpsk_modulator: RTL and testbench
=================================

Name: bpsk_modulator

Overview:
- Downstream neighbour of the sine carrier generator in the BPSK transmit chain.
- Accepts data bytes over a valid/ready handshake and serialises them MSB-first.
- For each bit, selects the in-phase or inverted carrier sample and switches phase only on carrier-period boundaries.
- Drives the generator enable and presents the modulated sample stream to the DAC/channel stage.

Parameters:
- SAMPLE_NUMBER, 256: samples per carrier period; must match the generator.
- SAMPLE_WIDTH, 12: carrier/output sample width.
- PERIODS_PER_BIT, 1: carrier periods per transmitted bit; legal range is 1 or more.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- data_in  in  8  byte to transmit.
- data_valid  in  1  data_in is valid.
- data_ready  out  1  block accepts data_in on this cycle when data_valid is also high.
- sine_in  in  SAMPLE_WIDTH  carrier sample from the generator.
- neg_sine_in  in  SAMPLE_WIDTH  inverted carrier sample from the generator.
- sample_idx  in  $clog2(SAMPLE_NUMBER)  generator sample counter.
- carrier_en  out  1  enable to the generator.
- mod_out  out  SAMPLE_WIDTH  modulated sample.
- mod_valid  out  1  mod_out carries a data-bearing sample.
- busy  out  1  a byte is held or being sent.

Behaviour:
- Reset values: carrier_en=0, data_ready=0, mod_out=0, mod_valid=0, busy=0. Shift register, bit counter and period counter all clear to 0. State is IDLE.
- carrier_en goes to 1 on the first cycle after rst is released and stays at 1 until the next reset. The generator therefore never outputs z while this block is running.
- Alignment: the generator output lags its counter by one cycle. The block registers sample_idx into idx_d, so sine_in and neg_sine_in correspond to idx_d.
  - Period start: idx_d == 0.
  - Period end: idx_d == SAMPLE_NUMBER-1.
- State IDLE:
  - data_ready=1, busy=0, mod_valid=0, mod_out=0.
  - data_valid & data_ready: capture data_in into the shift register and go to ALIGN.
- State ALIGN:
  - data_ready=0, busy=1, mod_valid=0.
  - On the cycle where idx_d == 0, go to TX and output the first sample in that same cycle.
  - If idx_d is already 0 on the cycle after capture, that cycle is the first TX sample (no extra period is waited).
- State TX:
  - Every cycle: mod_out <= phase ? sine_in : neg_sine_in, mod_valid=1, busy=1. Here phase is the current MSB (bit 1 selects sine, bit 0 selects neg_sine).
  - Latency from sine_in to mod_out is 1 cycle.
  - Period counter: increments at each period end; wraps at PERIODS_PER_BIT-1.
  - Bit advance: at a period end with period counter == PERIODS_PER_BIT-1, shift left and increment the bit counter (0..7).
  - Byte end: a bit advance with bit counter == 7.
    - data_ready=1 combinationally during that cycle only.
    - If data_valid is high, load the next byte and stay in TX. This is back-to-back transmission with no gap and no ALIGN pass.
    - Otherwise go to IDLE. mod_valid falls on the following cycle.
- data_ready is 0 in ALIGN and on every TX cycle other than the byte-end cycle. data_in is ignored whenever data_ready is 0.
- A phase change is only visible at the first sample of a period (idx_d == 0). A bit never changes mid-period.
- Reset in any state, including mid-bit: all outputs return to their reset values on the next edge and the in-flight byte is discarded.
- The generator wrap (SAMPLE_NUMBER-1 to 0) needs no special handling; the period-end compare covers it.

Optional Feature:
- Macro: BPSK_DIFF_ENC_EN.
- With the macro defined (DBPSK): phase = data bit XOR ref. ref is updated to the transmitted phase at each bit advance. ref is cleared to 0 on reset and on entry to IDLE.
- Without the macro: phase = data bit directly, and no ref register exists.

Test Plan:
1. Reset, then send 0xA5 with PERIODS_PER_BIT=1 -> the first mod_valid sample is at idx_d==0. Over 8 periods mod_out equals sine, neg, sine, neg, neg, sine, neg, sine. mod_valid and busy then fall and data_ready returns to 1.
2. Hold data_valid high with 0xFF then 0x00 -> data_ready pulses exactly on the byte-end cycle. There are 16 contiguous mod_valid periods, 8 sine then 8 neg, with no gap.
3. Capture a byte while sample_idx is 100 -> state stays ALIGN with mod_valid=0 until idx_d wraps to 0, then TX starts; no sample leaks before that.
4. PERIODS_PER_BIT=3, send 0x80 -> 3 sine periods followed by 21 neg periods. Phase changes occur only at idx_d==0.
5. Assert rst mid-byte at bit 4 -> next cycle mod_out=0, mod_valid=0, data_ready=0, carrier_en=0. After release, a new 0x01 transmits cleanly.
6. BPSK_DIFF_ENC_EN defined, send 0x00 -> all neg periods. Send 0xFF -> alternating sine, neg, sine, ... starting with sine.

Source files
------------

// File: rtl/bpsk_modulator_if.sv
//------------------------------------------------------------------------------
// Module      : bpsk_modulator_if
// Description : Byte handshake, carrier sample and modulated output bundle
//               shared by the BPSK modulator and its neighbours.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bpsk_modulator_if #(
    parameter int SAMPLE_NUMBER = 256,
    parameter int SAMPLE_WIDTH  = 12
);
    localparam int IDX_W = (SAMPLE_NUMBER > 1) ? $clog2(SAMPLE_NUMBER) : 1;

    logic [7:0]              data_in;
    logic                    data_valid;
    logic                    data_ready;
    logic [SAMPLE_WIDTH-1:0] sine_in;
    logic [SAMPLE_WIDTH-1:0] neg_sine_in;
    logic [IDX_W-1:0]        sample_idx;
    logic                    carrier_en;
    logic [SAMPLE_WIDTH-1:0] mod_out;
    logic                    mod_valid;
    logic                    busy;

    modport slave (
        input  data_in, data_valid, sine_in, neg_sine_in, sample_idx,
        output data_ready, carrier_en, mod_out, mod_valid, busy
    );

    modport master (
        output data_in, data_valid, sine_in, neg_sine_in, sample_idx,
        input  data_ready, carrier_en, mod_out, mod_valid, busy
    );
endinterface

`default_nettype wire

// File: rtl/bpsk_modulator.sv
//------------------------------------------------------------------------------
// Module      : bpsk_modulator
// Description : Serialises bytes MSB-first onto the carrier, switching phase
//               only on carrier-period boundaries. Define BPSK_DIFF_ENC_EN for
//               differential (DBPSK) encoding.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bpsk_modulator #(
    parameter int SAMPLE_NUMBER   = 256,
    parameter int SAMPLE_WIDTH    = 12,
    parameter int PERIODS_PER_BIT = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    bpsk_modulator_if.slave   bus
);
    localparam int IDX_W  = (SAMPLE_NUMBER > 1) ? $clog2(SAMPLE_NUMBER) : 1;
    localparam int PCNT_W = (PERIODS_PER_BIT > 1) ? $clog2(PERIODS_PER_BIT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_TX    = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q;
    logic [7:0]              shift_q, shift_d;
    logic [2:0]              bit_cnt_q, bit_cnt_d;
    logic [PCNT_W-1:0]       per_cnt_q, per_cnt_d;
    logic                    carrier_en_q;
    logic [SAMPLE_WIDTH-1:0] mod_out_q, mod_out_d;
    logic                    mod_valid_q, mod_valid_d;
`ifdef BPSK_DIFF_ENC_EN
    logic                    ref_q, ref_d;
`endif

    logic w_period_start;
    logic w_period_end;
    logic w_last_period;
    logic w_sample_en;
    logic w_phase;
    logic w_ready;

    // idx_q lines up with sine_in/neg_sine_in, which lag the counter by a cycle
    always_comb begin
        w_period_start = (idx_q == '0);
        w_period_end   = (idx_q == IDX_W'(SAMPLE_NUMBER - 1));
        w_last_period  = (per_cnt_q == PCNT_W'(PERIODS_PER_BIT - 1));
        w_sample_en    = (state_q == S_TX) || ((state_q == S_ALIGN) && w_period_start);
`ifdef BPSK_DIFF_ENC_EN
        w_phase        = shift_q[7] ^ ref_q;
`else
        w_phase        = shift_q[7];
`endif
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        per_cnt_d   = per_cnt_q;
        mod_out_d   = '0;
        mod_valid_d = 1'b0;
        w_ready     = 1'b0;
`ifdef BPSK_DIFF_ENC_EN
        ref_d       = ref_q;
`endif
        case (state_q)
            S_IDLE: begin
                w_ready = carrier_en_q;
`ifdef BPSK_DIFF_ENC_EN
                ref_d   = 1'b0;
`endif
                if (bus.data_valid && carrier_en_q) begin
                    shift_d   = bus.data_in;
                    bit_cnt_d = '0;
                    per_cnt_d = '0;
                    state_d   = S_ALIGN;
                end
            end
            S_ALIGN, S_TX: begin
                if (w_sample_en) begin
                    state_d     = S_TX;
                    mod_out_d   = w_phase ? bus.sine_in : bus.neg_sine_in;
                    mod_valid_d = 1'b1;
                    if (w_period_end) begin
                        if (w_last_period) begin
                            per_cnt_d = '0;
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef BPSK_DIFF_ENC_EN
                            ref_d     = w_phase;
`endif
                            if (bit_cnt_q == 3'd7) begin
                                // byte end: the only TX cycle that accepts a new byte
                                w_ready = 1'b1;
                                if (bus.data_valid) begin
                                    shift_d = bus.data_in;
                                end else begin
                                    state_d = S_IDLE;
`ifdef BPSK_DIFF_ENC_EN
                                    ref_d   = 1'b0;
`endif
                                end
                            end
                        end else begin
                            per_cnt_d = per_cnt_q + PCNT_W'(1);
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            per_cnt_q    <= '0;
            carrier_en_q <= 1'b0;
            mod_out_q    <= '0;
            mod_valid_q  <= 1'b0;
`ifdef BPSK_DIFF_ENC_EN
            ref_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= bus.sample_idx;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            per_cnt_q    <= per_cnt_d;
            carrier_en_q <= 1'b1;
            mod_out_q    <= mod_out_d;
            mod_valid_q  <= mod_valid_d;
`ifdef BPSK_DIFF_ENC_EN
            ref_q        <= ref_d;
`endif
        end
    end

    assign bus.data_ready = w_ready;
    assign bus.carrier_en = carrier_en_q;
    assign bus.mod_out    = mod_out_q;
    assign bus.mod_valid  = mod_valid_q;
    assign bus.busy       = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_bpsk_modulator.sv
//------------------------------------------------------------------------------
// Module      : tb_bpsk_modulator
// Description : Directed bench for bpsk_modulator with a tagged carrier model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_bpsk_modulator;
    localparam int N = 256;
    localparam int W = 12;
`ifdef BPSK_DIFF_ENC_EN
    localparam bit DIFF = 1'b1;
`else
    localparam bit DIFF = 1'b0;
`endif

    logic clk;
    logic rst;
    logic sel;
    logic dv;
    logic [7:0] din;
    bit   ref_m;
    int   total;
    int   bad;
    int   n_wait;

    logic [7:0]   gen_idx;
    logic [W-1:0] gen_sine;
    logic [W-1:0] gen_neg;

    bpsk_modulator_if #(.SAMPLE_NUMBER(N), .SAMPLE_WIDTH(W)) if1 ();
    bpsk_modulator_if #(.SAMPLE_NUMBER(N), .SAMPLE_WIDTH(W)) if3 ();

    bpsk_modulator #(.SAMPLE_NUMBER(N), .SAMPLE_WIDTH(W), .PERIODS_PER_BIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(if1)
    );
    bpsk_modulator #(.SAMPLE_NUMBER(N), .SAMPLE_WIDTH(W), .PERIODS_PER_BIT(3)) u_dut3 (
        .clk(clk), .rst(rst), .bus(if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample tags: top nibble marks polarity, low byte is the sample index
    function automatic logic [W-1:0] sin_of(input int k);
        return {4'h4, k[7:0]};
    endfunction
    function automatic logic [W-1:0] neg_of(input int k);
        return {4'h8, k[7:0]};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            gen_idx  <= '0;
            gen_sine <= '0;
            gen_neg  <= '0;
        end else if (if1.carrier_en) begin
            gen_idx  <= gen_idx + 8'd1;
            gen_sine <= sin_of(int'(gen_idx));
            gen_neg  <= neg_of(int'(gen_idx));
        end
    end

    assign if1.sine_in     = gen_sine;
    assign if1.neg_sine_in = gen_neg;
    assign if1.sample_idx  = gen_idx;
    assign if1.data_in     = din;
    assign if1.data_valid  = dv & ~sel;
    assign if3.sine_in     = gen_sine;
    assign if3.neg_sine_in = gen_neg;
    assign if3.sample_idx  = gen_idx;
    assign if3.data_in     = din;
    assign if3.data_valid  = dv & sel;

    wire [W-1:0] obs_out   = sel ? if3.mod_out    : if1.mod_out;
    wire         obs_valid = sel ? if3.mod_valid  : if1.mod_valid;
    wire         obs_ready = sel ? if3.data_ready : if1.data_ready;
    wire         obs_busy  = sel ? if3.busy       : if1.busy;
    wire         obs_cen   = sel ? if3.carrier_en : if1.carrier_en;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cen"},   32'(obs_cen),   32'd0);
        chk({tag, "_ready"}, 32'(obs_ready), 32'd0);
        chk({tag, "_out"},   32'(obs_out),   32'd0);
        chk({tag, "_valid"}, 32'(obs_valid), 32'd0);
        chk({tag, "_busy"},  32'(obs_busy),  32'd0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, 32'(obs_valid), 32'd0);
        chk({tag, "_busy"},  32'(obs_busy),  32'd0);
        chk({tag, "_ready"}, 32'(obs_ready), 32'd1);
        chk({tag, "_out"},   32'(obs_out),   32'd0);
    endtask

    // Called at a negedge; returns just after the capturing edge
    task automatic send_byte(input logic [7:0] b, input bit keep);
        int n;
        din = b;
        dv  = 1'b1;
        n   = 0;
        while (obs_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(obs_ready), 32'd1);
        @(posedge clk);
        #1;
        if (!keep) dv = 1'b0;
    endtask

    // Waits for the first data sample; nothing may leak while aligning
    task automatic wait_mod_valid(input string tag, output int n);
        int nerr;
        n    = 0;
        nerr = 0;
        do begin
            @(negedge clk);
            n++;
            if (obs_valid !== 1'b1 &&
                (obs_ready !== 1'b0 || obs_busy !== 1'b1 || obs_out !== '0)) nerr++;
        end while (obs_valid !== 1'b1 && n < 2000);
        chk({tag, "_start"}, 32'(obs_valid), 32'd1);
        chk({tag, "_align_leak"}, 32'(nerr), 32'd0);
    endtask

    // kind: 0 mid-byte, 1 last period with next byte queued, 2 last period then idle
    task automatic check_period(input bit ph, input int kind, input string tag);
        int nerr;
        int fk;
        logic [W-1:0] exp_s;
        logic exp_r;
        logic exp_b;
        logic [W+2:0] got_f;
        logic [W+2:0] exp_f;
        nerr  = 0;
        fk    = 0;
        got_f = '0;
        exp_f = '0;
        for (int k = 0; k < N; k++) begin
            exp_s = ph ? sin_of(k) : neg_of(k);
            exp_r = (k == N-2) ? (kind != 0) : ((k == N-1) ? (kind == 2) : 1'b0);
            exp_b = !((k == N-1) && (kind == 2));
            if (obs_valid !== 1'b1 || obs_out !== exp_s || obs_ready !== exp_r || obs_busy !== exp_b) begin
                if (nerr == 0) begin
                    fk    = k;
                    got_f = {obs_valid, obs_ready, obs_busy, obs_out};
                    exp_f = {1'b1, exp_r, exp_b, exp_s};
                end
                nerr++;
            end
            @(negedge clk);
        end
        total++;
        assert (nerr === 0) else begin
            bad++;
            $error("FAIL %s: %0d bad samples, first k=%0d valid/ready/busy/out got %0h expected %0h",
                   tag, nerr, fk, got_f, exp_f);
        end
    endtask

    task automatic check_byte(input logic [7:0] b, input int ppb, input bit followed, input string tag);
        bit ph;
        for (int i = 7; i >= 0; i--) begin
            ph = b[i] ^ (DIFF & ref_m);
            for (int p = 0; p < ppb; p++) begin
                check_period(ph, ((i == 0) && (p == ppb-1)) ? (followed ? 1 : 2) : 0,
                             $sformatf("%s_b%0d_p%0d", tag, i, p));
            end
            if (DIFF) ref_m = ph;
        end
        if (!followed) ref_m = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        sel   = 1'b0;
        dv    = 1'b0;
        din   = 8'h00;
        ref_m = 1'b0;

        // reset state, then carrier enable and idle handshake
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        @(negedge clk);
        chk("rel_cen", 32'(obs_cen), 32'd1);
        chk("rel_ready", 32'(obs_ready), 32'd1);
        chk("rel_busy", 32'(obs_busy), 32'd0);

        // single byte 0xA5
        send_byte(8'hA5, 1'b0);
        wait_mod_valid("a5", n_wait);
        check_byte(8'hA5, 1, 1'b0, "a5");
        check_idle("a5_end");

        // back-to-back 0xFF then 0x00 with data_valid held
        send_byte(8'hFF, 1'b1);
        din = 8'h00;
        wait_mod_valid("ff", n_wait);
        check_byte(8'hFF, 1, 1'b1, "ff");
        dv = 1'b0;
        check_byte(8'h00, 1, 1'b0, "b2b00");
        check_idle("b2b_end");

        // capture while the generator counter reads 100
        n_wait = 0;
        while (gen_idx !== 8'd100 && n_wait < 1000) begin
            @(negedge clk);
            n_wait++;
        end
        chk("idx100_reach", 32'(gen_idx), 32'd100);
        send_byte(8'h3C, 1'b0);
        wait_mod_valid("idx100", n_wait);
        chk("idx100_latency", 32'(n_wait), 32'd158);
        check_byte(8'h3C, 1, 1'b0, "3c");
        check_idle("3c_end");

        // three periods per bit
        sel = 1'b1;
        @(negedge clk);
        send_byte(8'h80, 1'b0);
        wait_mod_valid("ppb3", n_wait);
        check_byte(8'h80, 3, 1'b0, "ppb3");
        check_idle("ppb3_end");
        sel = 1'b0;
        @(negedge clk);

        // reset in the middle of a byte
        send_byte(8'h5A, 1'b0);
        wait_mod_valid("mid", n_wait);
        for (int i = 7; i >= 4; i--) begin
            bit ph;
            ph = din[i] ^ (DIFF & ref_m);
            check_period(ph, 0, $sformatf("mid_b%0d", i));
            if (DIFF) ref_m = ph;
        end
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(negedge clk);
        rst   = 1'b0;
        ref_m = 1'b0;
        @(negedge clk);
        send_byte(8'h01, 1'b0);
        wait_mod_valid("post", n_wait);
        check_byte(8'h01, 1, 1'b0, "post01");
        check_idle("post_end");

        // all-zero and all-one bytes (plain or differential mapping)
        send_byte(8'h00, 1'b0);
        wait_mod_valid("z00", n_wait);
        check_byte(8'h00, 1, 1'b0, "z00");
        check_idle("z00_end");
        send_byte(8'hFF, 1'b0);
        wait_mod_valid("oFF", n_wait);
        check_byte(8'hFF, 1, 1'b0, "oFF");
        check_idle("oFF_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
